// File: rtl/fadd_pipe_hs.sv
// Three-stage IEEE-754-style floating-point add/subtract with valid/ready back-pressure.
// Stages: align (S1), add/sub (S2), normalise/round/special select (S3).
module fadd_pipe_hs #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   clrn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   sub,
    input  logic [1:0]             rm,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   s,
    output logic [TAG_W-1:0]       tag_out,
    output logic [3:0]             flags
);
    localparam int unsigned W  = EXP_W + MAN_W + 1;
    localparam int unsigned F  = MAN_W + 4;
    localparam int unsigned E1 = EXP_W + 1;
    localparam int unsigned M2 = MAN_W + 2;
    localparam logic [E1-1:0] EMAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic v1, v2, v3, r1, r2, r3;

    // Back-pressure chain: a stage may load when it is empty or its successor can load.
    assign r3        = ~v3 | out_ready;
    assign r2        = ~v2 | r3;
    assign r1        = ~v1 | r2;
    assign in_ready  = r1;
    assign out_valid = v3;

    // ---------------- S1: align ----------------
    logic                sa, sb, swap, op_sub, nan_a, nan_b, inf_a, inf_b, nan_r;
    logic [EXP_W-1:0]    ea, eb, el, es, el_eff, es_eff, diff;
    logic [MAN_W-1:0]    fa, fb;
    logic [MAN_W:0]      ml, ms;
    logic [2*F-1:0]      wide;
    logic [F-1:0]        fl_al, fs_al;
    logic                spec_c, inv_c, sign_c;
    logic [W-1:0]        spec_val_c;

    always_comb begin
        sa     = a[W-1];
        sb     = b[W-1] ^ sub;
        ea     = a[W-2:MAN_W];
        eb     = b[W-2:MAN_W];
        fa     = a[MAN_W-1:0];
        fb     = b[MAN_W-1:0];
        op_sub = sub ^ a[W-1] ^ b[W-1];
        swap   = b[W-2:0] > a[W-2:0];
        el     = swap ? eb : ea;
        es     = swap ? ea : eb;
        ml     = {el != '0, swap ? fb : fa};
        ms     = {es != '0, swap ? fa : fb};
        sign_c = swap ? sb : sa;
        // Denormals sit at the same scale as exponent 1.
        el_eff = (el == '0) ? EXP_W'(1) : el;
        es_eff = (es == '0) ? EXP_W'(1) : es;
        diff   = el_eff - es_eff;
        wide   = {ms, 3'b000, {F{1'b0}}} >> diff;
        fl_al  = {ml, 3'b000};
        if (32'(diff) >= 32'(MAN_W + 3))
            fs_al = {{(F-1){1'b0}}, |ms};
        else
            fs_al = {wide[2*F-1:F+1], wide[F] | (|wide[F-1:0])};

        nan_a  = (ea == '1) && (fa != '0);
        nan_b  = (eb == '1) && (fb != '0);
        inf_a  = (ea == '1) && (fa == '0);
        inf_b  = (eb == '1) && (fb == '0);
        nan_r  = nan_a | nan_b | (inf_a & inf_b & op_sub);
        spec_c = nan_a | nan_b | inf_a | inf_b;
        inv_c  = (nan_a & ~fa[MAN_W-1]) | (nan_b & ~fb[MAN_W-1]) | (inf_a & inf_b & op_sub);
        if (nan_r)
            spec_val_c = QNAN;
        else if (inf_a)
            spec_val_c = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else
            spec_val_c = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end

    logic             s1_sign, s1_sub, s1_spec, s1_inv;
    logic [EXP_W-1:0] s1_exp;
    logic [F-1:0]     s1_fl, s1_fs;
    logic [W-1:0]     s1_spec_val;
    logic [1:0]       s1_rm;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v1 <= 1'b0; s1_sign <= 1'b0; s1_sub <= 1'b0; s1_spec <= 1'b0; s1_inv <= 1'b0;
            s1_exp <= '0; s1_fl <= '0; s1_fs <= '0; s1_spec_val <= '0; s1_rm <= '0; s1_tag <= '0;
        end else if (r1) begin
            v1 <= in_valid; s1_sign <= sign_c; s1_sub <= op_sub; s1_spec <= spec_c; s1_inv <= inv_c;
            s1_exp <= el_eff; s1_fl <= fl_al; s1_fs <= fs_al; s1_spec_val <= spec_val_c;
            s1_rm <= rm; s1_tag <= tag_in;
        end
    end

    // ---------------- S2: add/sub ----------------
    logic             s2_sign, s2_sub, s2_spec, s2_inv;
    logic [EXP_W-1:0] s2_exp;
    logic [F:0]       s2_sum;
    logic [W-1:0]     s2_spec_val;
    logic [1:0]       s2_rm;
    logic [TAG_W-1:0] s2_tag;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v2 <= 1'b0; s2_sign <= 1'b0; s2_sub <= 1'b0; s2_spec <= 1'b0; s2_inv <= 1'b0;
            s2_exp <= '0; s2_sum <= '0; s2_spec_val <= '0; s2_rm <= '0; s2_tag <= '0;
        end else if (r2) begin
            v2 <= v1; s2_sign <= s1_sign; s2_sub <= s1_sub; s2_spec <= s1_spec; s2_inv <= s1_inv;
            s2_exp <= s1_exp;
            s2_sum <= s1_sub ? ({1'b0, s1_fl} - {1'b0, s1_fs}) : ({1'b0, s1_fl} + {1'b0, s1_fs});
            s2_spec_val <= s1_spec_val; s2_rm <= s1_rm; s2_tag <= s1_tag;
        end
    end

    // ---------------- S3: normalise, round, select ----------------
    logic [E1-1:0]    e0, e_n, e_f;
    logic [F-1:0]     n;
    logic [M2-1:0]    mant;
    logic [MAN_W-1:0] frac;
    logic             g, rs, lsb, inc, ovf, inx, unf, inf_sel;
    int               lz, lim, sh;
    logic [W-1:0]     res_c;
    logic [3:0]       flg_c;

    always_comb begin
        e0  = {1'b0, s2_exp};
        lz  = int'(F);
        for (int i = 0; i < int'(F); i++)
            if (s2_sum[i]) lz = int'(F) - 1 - i;
        lim = (e0 == '0) ? 0 : int'(e0) - 1;
        sh  = 0;
        if (s2_sum[F]) begin
            n   = {s2_sum[F:2], s2_sum[1] | s2_sum[0]};
            e_n = e0 + E1'(1);
        end else begin
            // Left shift stops at exponent 1 so tiny results stay denormal.
            sh  = (lz < lim) ? lz : lim;
            n   = s2_sum[F-1:0] << sh;
            e_n = e0 - E1'(sh);
        end
        lsb = n[3];
        g   = n[2];
        rs  = n[1] | n[0];
        case (s2_rm)
            2'b00:   inc = g & (rs | lsb);
            2'b01:   inc = s2_sign & (g | rs);
            2'b10:   inc = ~s2_sign & (g | rs);
            default: inc = 1'b0;
        endcase
        mant = {1'b0, n[F-1:3]} + M2'(inc);
        if (mant[MAN_W+1])
            e_f = e_n + E1'(1);
        else if (mant[MAN_W])
            e_f = e_n;
        else
            e_f = '0;
        frac    = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
        ovf     = e_f >= EMAX;
        inx     = g | rs | ovf;
        unf     = (e_f == '0) & inx;
        inf_sel = (s2_rm == 2'b00) | ((s2_rm == 2'b01) & s2_sign) | ((s2_rm == 2'b10) & ~s2_sign);
        res_c   = {s2_sign, e_f[EXP_W-1:0], frac};
        flg_c   = {1'b0, ovf, unf, inx};
        if (ovf)
            res_c = inf_sel ? {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {s2_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        if (s2_sum == '0) begin
            res_c = {s2_sub ? (s2_rm == 2'b01) : s2_sign, {(W-1){1'b0}}};
            flg_c = 4'b0000;
        end
        if (s2_spec) begin
            res_c = s2_spec_val;
            flg_c = {s2_inv, 3'b000};
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            v3 <= 1'b0; s <= '0; flags <= '0; tag_out <= '0;
        end else if (r3) begin
            v3 <= v2; s <= res_c; flags <= flg_c; tag_out <= s2_tag;
        end
    end
endmodule

// File: tb/tb_fadd_pipe_hs.sv
// Directed self-checking bench for fadd_pipe_hs: single and half precision,
// rounding, specials, back-pressure and asynchronous reset.
module tb_fadd_pipe_hs;
    logic        clk = 1'b0;
    logic        clrn;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a, b, s;
    logic [1:0]  rm;
    logic [3:0]  tag_in, tag_out, flags;

    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready;
    logic [15:0] h_a, h_b, h_s;
    logic [1:0]  h_rm;
    logic [3:0]  h_tag_in, h_tag_out, h_flags;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] bv [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic [31:0] sv [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                            32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

    always #5 clk = ~clk;

    fadd_pipe_hs #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut (
        .clk(clk), .clrn(clrn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .rm(rm), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .tag_out(tag_out), .flags(flags)
    );

    fadd_pipe_hs #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_half (
        .clk(clk), .clrn(clrn), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .rm(h_rm), .tag_in(h_tag_in),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .s(h_s), .tag_out(h_tag_out),
        .flags(h_flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One unstalled operation: checks accept, latency, result, flags and tag.
    task automatic do_op(input string nm, input bit half, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic [1:0] irm, input logic [3:0] itag,
                         input logic [31:0] es, input logic [3:0] ef);
        int cyc;
        @(negedge clk);
        if (half) begin
            h_a = ia[15:0]; h_b = ib[15:0]; h_sub = isub; h_rm = irm; h_tag_in = itag; h_in_valid = 1'b1;
        end else begin
            a = ia; b = ib; sub = isub; rm = irm; tag_in = itag; in_valid = 1'b1;
        end
        #1 check({nm, "/in_ready"}, half ? h_in_ready : in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        h_in_valid = 1'b0;
        cyc = 1;
        while (!(half ? h_out_valid : out_valid) && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "/out_valid"}, half ? h_out_valid : out_valid, 1);
        check({nm, "/latency"}, 32'(cyc), 3);
        check({nm, "/s"}, half ? {16'h0, h_s} : s, es);
        check({nm, "/flags"}, half ? h_flags : flags, ef);
        check({nm, "/tag"}, half ? h_tag_out : tag_out, itag);
    endtask

    // Eight ops with out_ready low for cycles 2..9; every valid output must be the next expected one.
    task automatic stream_test();
        int  sent, got;
        logic fire_in, fire_out;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 2 && c <= 9);
            in_valid  = (sent < 8);
            a = 32'h3F800000;
            b = bv[sent & 7];
            sub = 1'b0;
            rm = 2'b00;
            tag_in = 4'(sent);
            #1;
            fire_in  = in_valid & in_ready;
            fire_out = out_valid & out_ready;
            if (c == 6) begin
                check("bp/in_ready_low", in_ready, 0);
                check("bp/held_ops", 32'(sent), 3);
            end
            if (out_valid) begin
                check("bp/s", s, sv[got & 7]);
                check("bp/tag", tag_out, 32'(got));
            end
            if (fire_out) got++;
            if (fire_in) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp/count", 32'(got), 8);
    endtask

    task automatic reset_test();
        int stale;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 32'h3F800000; b = bv[i]; sub = 1'b0; rm = 2'b00; tag_in = 4'(9 + i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rst/pre_valid", out_valid, 1);
        clrn = 1'b0;
        #1;
        check("rst/out_valid", out_valid, 0);
        check("rst/s", s, 0);
        check("rst/tag", tag_out, 0);
        check("rst/flags", flags, 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        #1 check("rst/in_ready", in_ready, 1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst/no_stale", 32'(stale), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; rm = 2'b00; tag_in = '0; out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_rm = 2'b00; h_tag_in = '0; h_out_ready = 1'b1;
        #1;
        check("reset/out_valid", out_valid, 0);
        check("reset/s", s, 0);
        check("reset/flags", flags, 0);
        check("reset/tag", tag_out, 0);
        check("reset/h_out_valid", h_out_valid, 0);
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        #1 check("reset/in_ready", in_ready, 1);

        do_op("add_1_2",      0, 32'h3F800000, 32'h40000000, 0, 2'b00, 4'd5,  32'h40400000, 4'b0000);
        do_op("inf_m_inf",    0, 32'h7F800000, 32'h7F800000, 1, 2'b00, 4'd1,  32'h7FC00000, 4'b1000);
        do_op("snan",         0, 32'h7F800001, 32'h3F800000, 0, 2'b00, 4'd2,  32'h7FC00000, 4'b1000);
        do_op("qnan",         0, 32'h7FC00000, 32'h3F800000, 0, 2'b00, 4'd3,  32'h7FC00000, 4'b0000);
        do_op("ovf_rne",      0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b00, 4'd4,  32'h7F800000, 4'b0101);
        do_op("ovf_rz",       0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b11, 4'd6,  32'h7F7FFFFF, 4'b0101);
        do_op("tie_rne",      0, 32'h3F800000, 32'h33800000, 0, 2'b00, 4'd7,  32'h3F800000, 4'b0001);
        do_op("tie_rp",       0, 32'h3F800000, 32'h33800000, 0, 2'b10, 4'd8,  32'h3F800001, 4'b0001);
        do_op("neg_rm",       0, 32'hBF800000, 32'hB3800000, 0, 2'b01, 4'd9,  32'hBF800001, 4'b0001);
        do_op("rnd_carry",    0, 32'h3FFFFFFF, 32'h33800000, 0, 2'b00, 4'd10, 32'h40000000, 4'b0001);
        do_op("zero_rm",      0, 32'h40400000, 32'h40400000, 1, 2'b01, 4'd11, 32'h80000000, 4'b0000);
        do_op("zero_rne",     0, 32'h40400000, 32'h40400000, 1, 2'b00, 4'd12, 32'h00000000, 4'b0000);
        do_op("negzero",      0, 32'h80000000, 32'h80000000, 0, 2'b00, 4'd13, 32'h80000000, 4'b0000);
        do_op("sub_neg",      0, 32'h3F800000, 32'h40000000, 1, 2'b00, 4'd14, 32'hBF800000, 4'b0000);
        do_op("fin_m_inf",    0, 32'h3F800000, 32'h7F800000, 1, 2'b00, 4'd15, 32'hFF800000, 4'b0000);
        do_op("denorm",       0, 32'h00000001, 32'h00000001, 0, 2'b00, 4'd0,  32'h00000002, 4'b0000);
        do_op("denorm_norm",  0, 32'h00400000, 32'h00400000, 0, 2'b00, 4'd1,  32'h00800000, 4'b0000);
        do_op("h_add",        1, 32'h3C00, 32'h3C00, 0, 2'b00, 4'd2, 32'h4000, 4'b0000);
        do_op("h_ovf",        1, 32'h7BFF, 32'h7BFF, 0, 2'b00, 4'd3, 32'h7C00, 4'b0101);
        do_op("h_sub",        1, 32'h4000, 32'h3C00, 1, 2'b00, 4'd4, 32'h3C00, 4'b0000);

        stream_test();
        reset_test();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fadd_pipe_hs.md
Name: fadd_pipe_hs

Overview:
- Parametrised 3-stage floating-point add/subtract unit, the successor to the fixed single-precision pipelined adder.
- Generalised to any IEEE-754-style format via EXP_W/MAN_W.
- Uses a valid/ready handshake with full back-pressure in place of a global enable, carries a user tag, and reports IEEE exception flags.
- Sits between the FPU issue logic and the writeback arbiter.

Parameters:
EXP_W, 8, exponent field width (>=3)
MAN_W, 23, stored fraction width (>=2)
TAG_W, 4, width of the opaque tag carried with each operation

Ports:
clk  in  1  clock, all state updates on rising edge
clrn  in  1  asynchronous active-low reset
in_valid  in  1  operands and op presented
in_ready  out  1  unit can accept this cycle
a  in  EXP_W+MAN_W+1  operand A {sign,exp,frac}
b  in  EXP_W+MAN_W+1  operand B
sub  in  1  1: A-B, 0: A+B
rm  in  2  00 nearest-even, 01 toward -inf, 10 toward +inf, 11 toward zero
tag_in  in  TAG_W  user tag
out_valid  out  1  result held on s/flags/tag_out
out_ready  in  1  consumer accepts this cycle
s  out  EXP_W+MAN_W+1  result
tag_out  out  TAG_W  tag of result
flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Datapath stages:
  - S1 align: swap by magnitude, detect specials, shift the smaller fraction into a MAN_W+4-bit field with guard, round and sticky bits.
  - S2 add/sub: (MAN_W+5)-bit add or subtract.
  - S3: leading-zero normalise, round, special-case select.
- Registers and per-stage valid bits:
  - Registered boundaries after S1, S2 and S3; the S3 register drives s/flags/tag_out directly.
  - Each register has a valid bit v1, v2, v3; out_valid = v3.
- Handshake:
  - r3 = ~v3 | out_ready; r2 = ~v2 | r3; r1 = ~v1 | r2; in_ready = r1.
  - The combinational out_ready -> in_ready path is accepted.
  - Stage k loads when rk=1: vk <= previous valid and data is captured; when rk=0 it holds.
- Latency and ordering:
  - Accept at edge N gives out_valid=1 after edge N+2 when unstalled, i.e. 3 cycles. Throughput is 1 op/cycle.
  - Results leave strictly in order. No op is dropped or duplicated under any out_ready pattern.
- Output hold: while out_valid=1 and out_ready=0, s, flags and tag_out are stable.
- Reset: asynchronous with clrn=0. v1..v3=0, out_valid=0, s=0, tag_out=0, flags=0, all pipeline data registers=0. Ops in flight are discarded. in_ready=1 once clrn is deasserted.
- Effective operation: op_sub = sub ^ sign_a ^ sign_b.
- Result sign:
  - Normally the sign of the larger-magnitude operand, with B's sign inverted when sub=1.
  - Exact-zero result from operands of opposite effective sign: +0, except -0 when rm=01.
  - (-0)+(-0) gives -0.
- Denormals: fully supported as inputs and outputs, no flush. A hidden bit is 0 when exp=0, and a denormal shift uses exp_diff-1.
- Alignment: shift amounts >= MAN_W+3 collapse the small fraction entirely into the sticky bit.
- Rounding:
  - On the guard/round/sticky bits per rm.
  - A carry out of rounding increments the exponent.
  - A denormal that rounds up to the minimum normal gets exp=1.
- Overflow: when the biased exponent reaches all-ones after normalise or rounding:
  - rm=00: infinity.
  - rm=11: max finite.
  - rm=01: infinity if negative, otherwise max finite.
  - rm=10: infinity if positive, otherwise max finite.
  - Sets overflow and inexact.
- NaN:
  - Any NaN input, or inf-inf under effective subtract, gives the canonical quiet NaN {0, all-ones exp, frac MSB 1, rest 0}.
  - invalid=1 for a signalling NaN input (frac MSB 0, frac≠0) or inf-inf.
  - A quiet NaN input alone gives invalid=0.
- Infinity: inf ± finite gives that inf with its effective sign, flags=0.
- Flags:
  - inexact: any nonzero guard/round/sticky bit, or overflow.
  - underflow: the rounded result is denormal or zero AND inexact.
  - Flags travel with their op and are valid only when out_valid=1.

Test Plan:
- a=3F800000, b=40000000, sub=0, rm=00, tag=5, out_ready=1 -> out_valid exactly 3 cycles after accept, s=40400000, flags=0000, tag_out=5.
- a=7F800000, b=7F800000, sub=1 -> s=7FC00000, flags=1000. Also a=7F800001 (sNaN) + 3F800000 -> s=7FC00000, invalid=1.
- a=b=7F7FFFFF, sub=0, rm=00 -> s=7F800000, flags=0101. Same operands with rm=11 -> s=7F7FFFFF, flags=0101.
- Rounding and zero sign:
  - a=3F800000 + b=33800000 (tie), rm=00 -> s=3F800000, inexact=1.
  - Same operands with rm=10 -> s=3F800001.
  - a=b=40400000, sub=1: rm=01 -> 80000000; rm=00 -> 00000000.
- Denormal and back-pressure:
  - a=00000001 + b=00000001 -> s=00000002, flags=0000.
  - Stream 8 ops with tags 0..7 while out_ready is held low for cycles 2-9 -> in_ready=0 once 3 ops are held, s is stable while stalled, all 8 results emerge in tag order with no loss.
- Reset and half precision:
  - Assert clrn low with 3 ops in flight -> out_valid drops to 0 immediately and no stale result appears after release.
  - With EXP_W=5, MAN_W=10: 3C00+3C00 -> 4000, and 7BFF+7BFF, rm=00 -> 7C00, flags=0101.
